alu4_seq: RTL and testbench
===========================

# alu4_seq

Nibble-serial wide-ALU sequencer that drives the existing `alu4` 74181-style slice from the operand side. A WIDTH-bit request is accepted over a valid/ready handshake, fed through one internal `alu4` instance one nibble per cycle, LSB nibble first, with the active-low carry rippled through a register. The assembled result is returned over a second valid/ready handshake. It replaces the random-stimulus driving of `alu4` with a synthesizable front end for wide datapath use.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  high only in IDLE.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_s  in  4  function select, passed unchanged to every nibble.
- op_m  in  1  1 = logic mode, 0 = arithmetic mode.
- op_cin  in  1  active-high carry-in; inverted onto nibble 0 `cin_re`.
- res_valid  out  1  result held stable until accepted.
- res_ready  in  1  consumer accepts the result.
- res_y  out  WIDTH  result.
- res_cout  out  1  active-high carry-out, taken from the last nibble.

## Operation
- States:
  - IDLE: in_ready=1. On `in_valid`, capture op_a, op_b, op_s, op_m, op_cin; set idx=0; carry_re=~op_cin; go to RUN.
  - RUN: drive alu4 with a=op_a[4*idx+:4], b=op_b[4*idx+:4], s, m, cin_re=carry_re.
    - Each edge: res_y[4*idx+:4] <= y; carry_re <= cout_re; idx++.
    - After nibble NIBBLES-1 is captured, go to DONE.
  - DONE: res_valid=1; res_cout=~carry_re. On res_ready, go to IDLE.
- Carry on the internal `alu4` ports is active-low (74181 convention); `op_cin` and `res_cout` are active-high.
- In logic mode (op_m=1), `alu4` ignores carry. `res_cout` still reports the final registered `cout_re` inverted; consumers must treat it as don't-care.
- No other status outputs.
- Reset values: state=IDLE, in_ready=1, res_valid=0, res_y=0, res_cout=0, idx=0, carry_re=1, captured operands=0.
- Reset asserted mid-RUN or in DONE aborts the operation with no result pulse. After release, the block is in IDLE.
- res_y and res_cout are unchanged while in DONE; they change only in RUN.

## Timing
- Request accepted on edge E0 (in_valid & in_ready).
- Nibble k is captured on edge E0+1+k.
- res_valid rises after edge E0+NIBBLES: 4 cycles for WIDTH=16.
- res_valid falls on the edge where res_ready=1. in_ready is high in the following cycle.
- Minimum issue interval is NIBBLES+2 cycles: 6 for WIDTH=16.
- in_valid is ignored outside IDLE. A request presented in the same cycle as a DONE→IDLE transition is not accepted until the next cycle.
- res_ready held low keeps DONE, with all outputs stable, indefinitely.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined:
  - adds output `res_zero` (1 bit), registered in DONE as (res_y == 0);
  - reset value 0; valid only while res_valid=1.
- Undefined: no `res_zero` port and no comparator logic; all other behaviour identical.

## Structure
- Shared package `alu_seq_pkg`:
  - state enum {IDLE, RUN, DONE};
  - function-select constants S_ADD=4'b1001 and S_SUB=4'b0110;
  - NIBBLE_W=4.
- One sub-module: the existing `alu4`, instantiated once, with its ports driven directly from the sequencer datapath.
- The idx counter is $clog2(WIDTH/4) bits wide, with a minimum of 1.

## Test plan
- Add: op_s=1001, op_m=0, op_cin=0, A=0x1234, B=0x0FCD → res_y=0x2201, res_cout=0; res_valid rises 4 cycles after accept.
- Add with overflow: A=0xFFFF, B=0x0001, op_cin=0 → res_y=0x0000, res_cout=1. With ALU_SEQ_ZERO_FLAG_EN defined, res_zero=1.
- Subtract: op_s=0110, op_m=0, op_cin=1, A=0x5000, B=0x0001 → res_y=0x4FFF, res_cout=1 (no borrow).
- Logic XOR: op_s=0110, op_m=1, A=0xF0F0, B=0x0FF0 → res_y=0xFF00.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → res_y stable, in_ready=0, second in_valid ignored. Then res_ready=1 → IDLE next cycle.
- Reset during RUN: assert reset after nibble 1 is captured → res_valid never pulses, in_ready=1, res_y=0. A following add returns a correct result.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer and its alu4 slice.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    // Common 74181 function selects (arithmetic mode)
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Index counter width: enough to address every nibble, never narrower than one bit
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/alu4.sv
// 74181-style 4-bit ALU slice: active-high data, active-low carry in/out.
module alu4
    import alu_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [3:0]          s,
    input  logic                m,
    input  logic                cin_re,
    output logic [NIBBLE_W-1:0] y,
    output logic                cout_re
);

    logic [NIBBLE_W-1:0] x_term;
    logic [NIBBLE_W-1:0] y_term;
    logic [NIBBLE_W-1:0] logic_f;
    logic [NIBBLE_W:0]   sum;

    // Arithmetic mode is the sum of two select-gated terms plus the carry
    always_comb begin
        x_term = a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}});
        y_term = (a & ~b & {NIBBLE_W{s[2]}}) | (a & b & {NIBBLE_W{s[3]}});
        sum    = {1'b0, x_term} + {1'b0, y_term} + {{NIBBLE_W{1'b0}}, ~cin_re};
    end

    always_comb begin
        logic_f = '0;
        case (s)
            4'b0000: logic_f = ~a;
            4'b0001: logic_f = ~(a | b);
            4'b0010: logic_f = ~a & b;
            4'b0011: logic_f = '0;
            4'b0100: logic_f = ~(a & b);
            4'b0101: logic_f = ~b;
            4'b0110: logic_f = a ^ b;
            4'b0111: logic_f = a & ~b;
            4'b1000: logic_f = ~a | b;
            4'b1001: logic_f = ~(a ^ b);
            4'b1010: logic_f = b;
            4'b1011: logic_f = a & b;
            4'b1100: logic_f = '1;
            4'b1101: logic_f = a | ~b;
            4'b1110: logic_f = a | b;
            4'b1111: logic_f = a;
            default: logic_f = '0;
        endcase
    end

    assign y       = m ? logic_f : sum[NIBBLE_W-1:0];
    assign cout_re = ~sum[NIBBLE_W];

endmodule

// File: rtl/alu4_seq.sv
// Nibble-serial wide ALU: feeds one alu4 slice LSB nibble first with a registered ripple carry.
// Optional ALU_SEQ_ZERO_FLAG_EN adds a registered res_zero output.
module alu4_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic             res_zero
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_re_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [3:0]         s_reg;
    logic               m_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               cout_reg;
    logic               in_ready_reg;
    logic               valid_reg;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic               zero_reg;
`endif

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] alu_y;
    logic                alu_cout_re;
    logic [WIDTH-1:0]    y_next;

    // Nibble views of the captured operands, and the result with the current nibble merged in
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign y_next[gi*NIBBLE_W +: NIBBLE_W] =
                (idx_reg == IDX_W'(gi)) ? alu_y : y_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    alu4 u_alu4 (
        .a       (a_nib[idx_reg]),
        .b       (b_nib[idx_reg]),
        .s       (s_reg),
        .m       (m_reg),
        .cin_re  (carry_re_reg),
        .y       (alu_y),
        .cout_re (alu_cout_re)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            carry_re_reg <= 1'b1;
            a_reg        <= '0;
            b_reg        <= '0;
            s_reg        <= '0;
            m_reg        <= 1'b0;
            y_reg        <= '0;
            cout_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
            valid_reg    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= op_a;
                        b_reg        <= op_b;
                        s_reg        <= op_s;
                        m_reg        <= op_m;
                        carry_re_reg <= ~op_cin;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    y_reg        <= y_next;
                    carry_re_reg <= alu_cout_re;
                    if (idx_reg == LAST_IDX) begin
                        // Final carry goes straight to res_cout; it equals carry_re once in DONE
                        cout_reg  <= ~alu_cout_re;
                        valid_reg <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= DONE;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                        zero_reg  <= (y_next == '0);
`endif
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        valid_reg    <= 1'b0;
                        in_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                    valid_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign res_valid = valid_reg;
    assign res_y     = y_reg;
    assign res_cout  = cout_reg;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero  = zero_reg;
`endif

endmodule

// File: tb/tb_alu4_seq.sv
// Self-checking bench for alu4_seq: directed vector table, handshake corner cases, random ops vs full-width model.
module tb_alu4_seq;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [3:0]  op_s = '0;
    logic        op_m = 1'b0;
    logic        op_cin = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_y;
    logic        res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        res_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu4_seq #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_s      (op_s),
        .op_m      (op_m),
        .op_cin    (op_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_cout  (res_cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Whole-word 74181 behaviour: {carry_out, result} with active-high carry
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic cin);
        logic [16:0] ea, eb, nb, c, ones, r;
        logic [15:0] l;
        ea = {1'b0, a};
        eb = {1'b0, b};
        nb = {1'b0, ~b};
        c  = {16'h0, cin};
        ones = 17'h0FFFF;
        r = '0;
        l = '0;
        if (m) begin
            case (s)
                4'b0000: l = ~a;
                4'b0001: l = ~(a | b);
                4'b0010: l = ~a & b;
                4'b0011: l = 16'h0000;
                4'b0100: l = ~(a & b);
                4'b0101: l = ~b;
                4'b0110: l = a ^ b;
                4'b0111: l = a & ~b;
                4'b1000: l = ~a | b;
                4'b1001: l = ~(a ^ b);
                4'b1010: l = b;
                4'b1011: l = a & b;
                4'b1100: l = 16'hFFFF;
                4'b1101: l = a | ~b;
                4'b1110: l = a | b;
                default: l = a;
            endcase
            r = {1'b0, l};
        end else begin
            case (s)
                4'b0000: r = ea + c;
                4'b0001: r = (ea | eb) + c;
                4'b0010: r = (ea | nb) + c;
                4'b0011: r = ones + c;
                4'b0100: r = ea + (ea & nb) + c;
                4'b0101: r = (ea | eb) + (ea & nb) + c;
                4'b0110: r = ea + nb + c;
                4'b0111: r = (ea & nb) + ones + c;
                4'b1000: r = ea + (ea & eb) + c;
                4'b1001: r = ea + eb + c;
                4'b1010: r = (ea | nb) + (ea & eb) + c;
                4'b1011: r = (ea & eb) + ones + c;
                4'b1100: r = ea + ea + c;
                4'b1101: r = (ea | eb) + ea + c;
                4'b1110: r = (ea | nb) + ea + c;
                default: r = ea + ones + c;
            endcase
        end
        return r;
    endfunction

    // Issues one request from IDLE, waits for the result, holds it for ready_delay cycles, then accepts it
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input int ready_delay,
                          output logic [15:0] y, output logic cout, output logic z, output int lat);
        bit ok;
        check("pre_in_ready", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b;
        lat = 0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
        check("res_valid_timeout", 32'(ok), 32'd1);
        y = res_y;
        cout = res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        z = res_zero;
`else
        z = 1'b0;
`endif
        for (int d = 0; d < ready_delay; d++) begin
            @(posedge clock); #1;
            check("hold_res_y", 32'(res_y), 32'(y));
        end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        check("post_res_valid", 32'(res_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        $display("op a=%h b=%h s=%b m=%0d cin=%0d -> y=%h cout=%0d lat=%0d", a, b, s, m, cin, y, cout, lat);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cin;
        logic [15:0] exp_y;
        logic        exp_cout;
        logic        chk_cout;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [15:0] y, held_y, ra, rb;
        logic [16:0] ref_r;
        logic        cout, z, rm, rc, seen;
        logic [3:0]  rs;
        int          lat;

        vecs[0] = '{16'h1234, 16'h0FCD, S_ADD,   1'b0, 1'b0, 16'h2201, 1'b0, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'h5000, 16'h0001, S_SUB,   1'b0, 1'b1, 16'h4FFF, 1'b1, 1'b1};
        vecs[3] = '{16'hF0F0, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0};
        vecs[4] = '{16'h00FF, 16'h1234, 4'b0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h5555, 4'b1111, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[6] = '{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_y", 32'(res_y), 32'd0);
        check("rst_res_cout", 32'(res_cout), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, i % 3, y, cout, z, lat);
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
            if (vecs[i].chk_cout)
                check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
`ifdef ALU_SEQ_ZERO_FLAG_EN
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_y == 16'h0000));
`endif
        end

        // Backpressure: result held, extra requests ignored, release-cycle request not accepted
        op_a = 16'h1111; op_b = 16'h2222; op_s = S_ADD; op_m = 1'b0; op_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clock); #1;
            seen = res_valid;
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        held_y = res_y;
        check("bp_result", 32'(held_y), 32'h3333);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_res_y", 32'(res_y), 32'(held_y));
        end
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (res_valid) seen = 1'b1;
        end
        check("bp_no_phantom_result", 32'(seen), 32'd0);
        $display("backpressure held y=%h for 10 cycles", held_y);

        // Reset after nibble 1 is captured
        op_a = 16'h1234; op_b = 16'h4321; op_s = S_ADD; op_m = 1'b0; op_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("rr_res_valid", 32'(res_valid), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd1);
        check("rr_res_y", 32'(res_y), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (res_valid) seen = 1'b1;
        end
        check("rr_no_result", 32'(seen), 32'd0);
        check("rr_idle", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h0FCD, S_ADD, 1'b0, 1'b0, 0, y, cout, z, lat);
        check("rr_add_y", 32'(y), 32'h2201);
        check("rr_add_cout", 32'(cout), 32'd0);
        $display("reset during RUN aborted cleanly");

        // Random operations against the whole-word model
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ref_r = model(ra, rb, rs, rm, rc);
            run_op(ra, rb, rs, rm, rc, int'($urandom_range(0, 3)), y, cout, z, lat);
            check($sformatf("rnd%0d_y", i), 32'(y), 32'(ref_r[15:0]));
            if (!rm)
                check($sformatf("rnd%0d_cout", i), 32'(cout), 32'(ref_r[16]));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
`ifdef ALU_SEQ_ZERO_FLAG_EN
            check($sformatf("rnd%0d_zero", i), 32'(z), 32'(ref_r[15:0] == 16'h0000));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
